// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared definitions for the pipeline step controller:
// state encoding and default drain depth.
package pipeline_step_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam int N_DRAIN_DEF = 3;

endpackage

// File: rtl/pipeline_step_ctrl.sv
// Run/step/halt sequencer for the pipeline registers,
// with post-halt drain and a saturating step counter.
module pipeline_step_ctrl
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int NB       = 32,
  parameter int N_DRAIN  = N_DRAIN_DEF,
  parameter int NB_DRAIN = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_run,
  input  logic          i_cmd_step,
  input  logic          i_cmd_stop,
  input  logic          i_cmd_clear,
  input  logic          i_halt_detected,
  output logic          o_step,
  output logic          o_pc_enable,
  output logic          o_halted,
  output logic          o_busy,
  output logic [NB-1:0] o_cycle_count
);

  localparam logic [NB-1:0] CNT_MAX = '1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD =
    NB_DRAIN'(N_DRAIN - 1);

  state_t              state;
  state_t              nxt;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic                clr_ok;

  // stop outranks step, which outranks run
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (i_cmd_stop)      nxt = IDLE;
        else if (i_cmd_step) nxt = STEP;
        else if (i_cmd_run)  nxt = RUN;
      end
      RUN: begin
        if (i_halt_detected) nxt = DRAIN;
        else if (i_cmd_stop) nxt = IDLE;
      end
      STEP:
        nxt = i_halt_detected ? DRAIN : IDLE;
      DRAIN:
        if (drain_cnt == '0) nxt = HALTED;
      HALTED:
        if (i_cmd_clear) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  assign clr_ok = i_cmd_clear &&
                  (state == IDLE || state == HALTED);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      o_step        <= 1'b0;
      o_pc_enable   <= 1'b0;
      o_halted      <= 1'b0;
      o_busy        <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state <= nxt;
      if (nxt == DRAIN && state != DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN)
        drain_cnt <= drain_cnt - 1'b1;
      o_step      <= nxt == RUN || nxt == STEP ||
                     nxt == DRAIN;
      o_busy      <= nxt == RUN || nxt == STEP ||
                     nxt == DRAIN;
      o_pc_enable <= nxt == RUN || nxt == STEP;
      o_halted    <= nxt == HALTED;
      if (clr_ok)
        o_cycle_count <= '0;
      else if (o_step && o_cycle_count != CNT_MAX)
        o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

endmodule
